// File: rtl/kalman_matmul2x2.sv
// 2x2 signed fixed-point matrix multiply C = A*B for the Kalman sequencer; one MAC per cycle.
// Latency: done pulses 9 cycles after the start cycle (8 MAC steps, result registered on the last).
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
// Optional: define KALMAN_MATMUL_SAT_EN to saturate results instead of wrapping.
module kalman_matmul2x2 #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [4*DW-1:0] a_flat,
    input  logic [4*DW-1:0] b_flat,
    output logic [4*DW-1:0] c_flat,
    output logic            busy,
    output logic            done
);

    // Full-precision accumulator: two DWxDW products need one extra bit.
    localparam int AW = 2*DW + 1;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t              state;
    logic [4*DW-1:0]     a_reg;
    logic [4*DW-1:0]     b_reg;
    logic signed [AW-1:0] acc;
    logic [2:0]          step;
    // Finished, scaled elements {c10, c01, c00} waiting for c11.
    logic [3*DW-1:0]     stage;

    logic [1:0]              a_idx;
    logic [1:0]              b_idx;
    logic signed [DW-1:0]    a_op;
    logic signed [DW-1:0]    b_op;
    logic signed [2*DW-1:0]  prod;
    logic signed [AW-1:0]    sum;
    logic signed [AW-1:0]    scaled;
    logic [DW-1:0]           elem;

`ifdef KALMAN_MATMUL_SAT_EN
    localparam logic signed [AW-1:0] MAX_V = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
`else
    // Wrapping keeps only the low DW bits of the scaled value.
    logic unused_scaled_hi;
    assign unused_scaled_hi = ^scaled[AW-1:DW];
`endif

    // Operand select, product, running sum and scaling of the finishing element.
    // Step k: element k/2 (row = bit2, col = bit1), term k%2 (bit0).
    always_comb begin
        a_idx  = {step[2], step[0]};
        b_idx  = {step[0], step[1]};
        a_op   = a_reg[DW*int'(a_idx) +: DW];
        b_op   = b_reg[DW*int'(b_idx) +: DW];
        prod   = a_op * b_op;
        sum    = acc + {prod[2*DW-1], prod};
        scaled = sum >>> FRAC;
`ifdef KALMAN_MATMUL_SAT_EN
        if (scaled > MAX_V) begin
            elem = MAX_V[DW-1:0];
        end else if (scaled < MIN_V) begin
            elem = MIN_V[DW-1:0];
        end else begin
            elem = scaled[DW-1:0];
        end
`else
        elem = scaled[DW-1:0];
`endif
    end

    // Control FSM and datapath registers; all four results publish together with done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            step   <= '0;
            stage  <= '0;
            c_flat <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_flat;
                        b_reg <= b_flat;
                        acc   <= '0;
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    step <= step + 3'd1;
                    if (step[0]) begin
                        acc <= '0;
                        if (step == 3'd7) begin
                            c_flat <= {elem, stage};
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            stage[DW*int'(step[2:1]) +: DW] <= elem;
                        end
                    end else begin
                        acc <= sum;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kalman_matmul2x2.sv
// Directed bench for kalman_matmul2x2: reset, identity, mixed-sign, truncation, overflow,
// back-to-back starts, ignored starts and mid-computation reset.
// Samples are taken 1 time unit after each rising edge; sample 1 follows the accepting edge.
module tb_kalman_matmul2x2;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [63:0]   a_flat;
    logic [63:0]   b_flat;
    logic [63:0]   c_flat;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kalman_matmul2x2 #(.DW(DW), .FRAC(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a_flat  (a_flat),
        .b_flat  (b_flat),
        .c_flat  (c_flat),
        .busy    (busy),
        .done    (done)
    );

    function automatic logic [63:0] mk(input logic [15:0] e00, input logic [15:0] e01,
                                       input logic [15:0] e10, input logic [15:0] e11);
        return {e11, e10, e01, e00};
    endfunction

    // Identity operands and a mixed-value operand set with hand-computed product.
    localparam logic [63:0] ID_A  = {16'h0100, 16'h0000, 16'h0000, 16'h0100};
    localparam logic [63:0] ID_B  = {16'h0100, 16'hFF00, 16'h0080, 16'h0200};
    // A = [1.5 2; -0.5 0.25], B = [1 -1; 0.5 2] -> C = [2.5 2.5; -0.375 1.0]
    localparam logic [63:0] GEN_A = {16'h0040, 16'hFF80, 16'h0200, 16'h0180};
    localparam logic [63:0] GEN_B = {16'h0200, 16'h0080, 16'hFF00, 16'h0100};
    localparam logic [63:0] GEN_C = {16'h0100, 16'hFFA0, 16'h0280, 16'h0280};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launch one operation from IDLE, scramble the inputs after acceptance and
    // observe 14 samples, recording first done sample index and result.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] c, output int done_at,
                         output int busy_cnt, output int done_cnt);
        a_flat = a;
        b_flat = b;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        a_flat = ~a;
        b_flat = b ^ 64'h1234_5678_9ABC_DEF0;
        done_at  = 0;
        busy_cnt = 0;
        done_cnt = 0;
        c        = '0;
        for (int i = 1; i <= 14; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = i;
                    c = c_flat;
                end
            end
            if (i < 14) tick;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        start   = 1'b0;
        a_flat  = GEN_A;
        b_flat  = GEN_B;
        repeat (3) tick;
        total++; if (c_flat !== 64'h0) begin bad++; $display("FAIL reset_c: got %h want %h", c_flat, 64'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_identity;
        logic [63:0] c;
        int da, bc, dc;
        do_op(ID_A, ID_B, c, da, bc, dc);
        total++; if (c !== ID_B) begin bad++; $display("FAIL ident_c: got %h want %h", c, ID_B); end
        total++; if (da !== 9) begin bad++; $display("FAIL ident_latency: got %0d want 9", da); end
        total++; if (bc !== 9) begin bad++; $display("FAIL ident_busy_cycles: got %0d want 9", bc); end
        total++; if (dc !== 1) begin bad++; $display("FAIL ident_done_count: got %0d want 1", dc); end
        total++; if (c_flat !== ID_B) begin bad++; $display("FAIL ident_hold: got %h want %h", c_flat, ID_B); end
    endtask

    task automatic test_general;
        logic [63:0] c;
        int da, bc, dc;
        do_op(GEN_A, GEN_B, c, da, bc, dc);
        total++; if (c !== GEN_C) begin bad++; $display("FAIL general_c: got %h want %h", c, GEN_C); end
        total++; if (da !== 9) begin bad++; $display("FAIL general_latency: got %0d want 9", da); end
    endtask

    task automatic test_sign;
        logic [63:0] c;
        int da, bc, dc;
        // -1.0 * 0.5 = -0.5
        do_op(mk(16'hFF00, 0, 0, 0), mk(16'h0080, 0, 0, 0), c, da, bc, dc);
        total++; if (c !== mk(16'hFF80, 0, 0, 0)) begin bad++; $display("FAIL sign_neg: got %h want %h", c, mk(16'hFF80, 0, 0, 0)); end
        // (-1/256)^2 = +1/65536 truncates to 0
        do_op(mk(16'hFFFF, 0, 0, 0), mk(16'hFFFF, 0, 0, 0), c, da, bc, dc);
        total++; if (c !== 64'h0) begin bad++; $display("FAIL trunc_pos: got %h want %h", c, 64'h0); end
        // -1/256 * 1/256 = -1/65536 truncates toward minus infinity to -1 LSB
        do_op(mk(16'hFFFF, 0, 0, 0), mk(16'h0001, 0, 0, 0), c, da, bc, dc);
        total++; if (c !== mk(16'hFFFF, 0, 0, 0)) begin bad++; $display("FAIL trunc_neg: got %h want %h", c, mk(16'hFFFF, 0, 0, 0)); end
    endtask

    task automatic test_overflow;
        logic [63:0] c;
        logic [63:0] exp_c;
        int da, bc, dc;
`ifdef KALMAN_MATMUL_SAT_EN
        exp_c = mk(16'h7FFF, 0, 0, 0);
`else
        exp_c = mk(16'hFE00, 0, 0, 0);
`endif
        do_op(mk(16'h7FFF, 16'h7FFF, 0, 0), mk(16'h7FFF, 0, 16'h7FFF, 0), c, da, bc, dc);
        total++; if (c !== exp_c) begin bad++; $display("FAIL overflow_c: got %h want %h", c, exp_c); end
    endtask

    task automatic test_back_to_back;
        int d[$];
        a_flat = ID_A;
        b_flat = ID_B;
        start  = 1'b1;
        for (int i = 1; i <= 35; i++) begin
            tick;
            if (done) d.push_back(i);
        end
        start = 1'b0;
        total++; if (d.size() !== 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", d.size()); end
        if (d.size() >= 3) begin
            total++; if (d[1] - d[0] !== 10) begin bad++; $display("FAIL b2b_period1: got %0d want 10", d[1] - d[0]); end
            total++; if (d[2] - d[1] !== 10) begin bad++; $display("FAIL b2b_period2: got %0d want 10", d[2] - d[1]); end
        end
        repeat (12) tick;
        total++; if (c_flat !== ID_B) begin bad++; $display("FAIL b2b_c: got %h want %h", c_flat, ID_B); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", busy); end
    endtask

    task automatic test_ignore_start;
        int dn = 0;
        a_flat = GEN_A;
        b_flat = GEN_B;
        start  = 1'b1;
        tick;
        for (int i = 1; i <= 20; i++) begin
            start = (i == 2 || i == 4 || i == 6) ? 1'b1 : 1'b0;
            if (done) dn++;
            tick;
        end
        start = 1'b0;
        total++; if (dn !== 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", dn); end
        total++; if (c_flat !== GEN_C) begin bad++; $display("FAIL ignore_c: got %h want %h", c_flat, GEN_C); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] c;
        int da, bc, dc;
        int dn = 0;
        a_flat = ID_A;
        b_flat = ID_B;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        repeat (4) tick;
        reset_n = 1'b0;
        #1;
        total++; if (c_flat !== 64'h0) begin bad++; $display("FAIL midrst_c: got %h want %h", c_flat, 64'h0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        repeat (3) begin
            tick;
            if (done) dn++;
        end
        reset_n = 1'b1;
        repeat (12) begin
            tick;
            if (done) dn++;
        end
        total++; if (dn !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d want 0", dn); end
        do_op(GEN_A, GEN_B, c, da, bc, dc);
        total++; if (c !== GEN_C) begin bad++; $display("FAIL midrst_restart_c: got %h want %h", c, GEN_C); end
        total++; if (da !== 9) begin bad++; $display("FAIL midrst_restart_latency: got %0d want 9", da); end
    endtask

    initial begin
        test_reset;
        test_identity;
        test_general;
        test_sign;
        test_overflow;
        test_back_to_back;
        test_ignore_start;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
